// File: rtl/adc_spi_sampler.sv
// Periodic SPI master for a 12-bit serial ADC. Each frame is a setup gap, lead bits and
// 12 data bits, and adc_value_o is held between frames. Define ADC_AVG_EN for a 4-sample moving average.
module adc_spi_sampler #(
  parameter int CLK_DIV       = 25,
  parameter int LEAD_BITS     = 3,
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        adc_miso_i,
  output logic        adc_sclk_o,
  output logic        adc_cs_n_o,
  output logic [11:0] adc_value_o,
  output logic        sample_valid_o,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o
);
  localparam int NBITS = LEAD_BITS + 12;
  localparam int PW    = $clog2(SAMPLE_PERIOD);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW    = $clog2(NBITS);

  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic [11:0]   shreg_q, shreg_d;
  logic [11:0]   value_q, value_d;
  logic          valid_q, valid_d;
  logic          miso_s1_q, miso_s2_q;
  logic          start;
  logic [11:0]   result;

`ifdef ADC_AVG_EN
  logic [11:0] hist0_q, hist1_q, hist2_q;
  logic [11:0] hist0_d, hist1_d, hist2_d;
  logic [13:0] sum;

  // Reset zeros count as samples until three real results have been seen.
  always_comb begin
    sum    = {2'b00, shreg_q} + {2'b00, hist0_q} + {2'b00, hist1_q} + {2'b00, hist2_q};
    result = sum[13:2];
  end
`else
  always_comb result = shreg_q;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    shreg_d = shreg_q;
    value_d = value_q;
    valid_d = 1'b0;
`ifdef ADC_AVG_EN
    hist0_d = hist0_q;
    hist1_d = hist1_q;
    hist2_d = hist2_q;
`endif
    if (!enable_i || per_q == PER_LAST) per_d = '0;
    else                                per_d = per_q + 1'b1;
    // A start arriving outside IDLE is simply dropped.
    start = enable_i && (per_q == '0) && (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (sclk_q) begin
            // End of high phase: sample the synchronized data bit.
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[10:0], miso_s2_q};
          end else if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
            cs_n_d  = 1'b1;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        value_d = result;
        valid_d = 1'b1;
`ifdef ADC_AVG_EN
        hist2_d = hist1_q;
        hist1_d = hist0_q;
        hist0_d = shreg_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      per_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      shreg_q   <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
`ifdef ADC_AVG_EN
      hist0_q   <= '0;
      hist1_q   <= '0;
      hist2_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      shreg_q   <= shreg_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      miso_s1_q <= adc_miso_i;
      miso_s2_q <= miso_s1_q;
`ifdef ADC_AVG_EN
      hist0_q   <= hist0_d;
      hist1_q   <= hist1_d;
      hist2_q   <= hist2_d;
`endif
    end
  end

  assign adc_sclk_o     = sclk_q;
  assign adc_cs_n_o     = cs_n_q;
  assign adc_value_o    = value_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = (state_q != S_IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: behavioural ADC, frame timing monitor and value scoreboard.
module tb_adc_spi_sampler;
  localparam int CLK_DIV       = 4;
  localparam int LEAD_BITS     = 3;
  localparam int SAMPLE_PERIOD = 200;
  localparam int FRAME_CYCLES  = CLK_DIV + 2 * CLK_DIV * (LEAD_BITS + 12) + 1;
  localparam int NBITS         = LEAD_BITS + 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        adc_miso = 1'b0;
  logic        adc_sclk, adc_cs_n, sample_valid, busy;
  logic [11:0] adc_value;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [11:0] exp_q[$];
  logic [14:0] frame_q[$];
  logic [11:0] m_hist[3];

  int fall_cnt = 0, fall_cyc = 0, edge_cyc = 0, rise_cnt = 0, valid_cnt = 0, en_cyc = 0;
  bit have_fall = 1'b0, en_rise_pend = 1'b0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0;
  logic [11:0] prev_value = '0;

  adc_spi_sampler #(
    .CLK_DIV      (CLK_DIV),
    .LEAD_BITS    (LEAD_BITS),
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .enable_i      (enable),
    .adc_miso_i    (adc_miso),
    .adc_sclk_o    (adc_sclk),
    .adc_cs_n_o    (adc_cs_n),
    .adc_value_o   (adc_value),
    .sample_valid_o(sample_valid),
    .busy_o        (busy),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- ADC model ----------------
  // Drives the first bit when cs_n falls and the next bit on each sclk falling edge;
  // outside a frame miso is random noise.
  logic [14:0] cur_frame = '0;
  int          bit_idx = 0;
  logic        a_cs_prev = 1'b1, a_sclk_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (a_cs_prev && !adc_cs_n) begin
      if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
      else                    cur_frame = 15'h7fff;
      bit_idx  = 0;
      adc_miso = cur_frame[14];
    end else if (!adc_cs_n && a_sclk_prev && !adc_sclk) begin
      bit_idx++;
      adc_miso = (bit_idx < NBITS) ? cur_frame[14 - bit_idx] : 1'b0;
    end else if (adc_cs_n) begin
      adc_miso = 1'($urandom_range(0, 1));
    end
    a_cs_prev   = adc_cs_n;
    a_sclk_prev = adc_sclk;
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (cs_prev && !adc_cs_n) begin
        fall_cnt++;
        check_val("busy_in_frame", busy, 1);
        if (en_rise_pend) begin
          check_val("enable_to_cs", cyc - en_cyc, 1);
          en_rise_pend = 1'b0;
        end else if (have_fall) begin
          check_val("cs_period", cyc - fall_cyc, SAMPLE_PERIOD);
        end
        have_fall = 1'b1;
        fall_cyc  = cyc;
        rise_cnt  = 0;
      end
      if (!sclk_prev && adc_sclk) begin
        rise_cnt++;
        if (rise_cnt == 1) check_val("cs_to_sclk", cyc - fall_cyc, CLK_DIV);
        else               check_val("sclk_low", cyc - edge_cyc, CLK_DIV);
        edge_cyc = cyc;
      end
      if (sclk_prev && !adc_sclk) begin
        check_val("sclk_high", cyc - edge_cyc, CLK_DIV);
        edge_cyc = cyc;
      end
      if (sample_valid) begin
        valid_cnt++;
        check_val("valid_latency", cyc - fall_cyc, FRAME_CYCLES);
        check_val("sclk_rises", rise_cnt, NBITS);
        if (exp_q.size() == 0) check_val("unexpected_valid", 1, 0);
        else                   check_val("adc_value", adc_value, exp_q.pop_front());
      end else if (adc_value !== prev_value) begin
        check_val("value_hold", adc_value, prev_value);
      end
    end
    cs_prev    = adc_cs_n;
    sclk_prev  = adc_sclk;
    prev_value = adc_value;
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input logic [11:0] raw);
`ifdef ADC_AVG_EN
    logic [13:0] s;
    s = {2'b00, raw} + {2'b00, m_hist[0]} + {2'b00, m_hist[1]} + {2'b00, m_hist[2]};
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = raw;
    exp_q.push_back(s[13:2]);
`else
    exp_q.push_back(raw);
`endif
  endtask

  task automatic queue_frame(input logic [2:0] lead, input logic [11:0] data);
    frame_q.push_back({lead, data});
    push_expected(data);
  endtask

  task automatic queue_abandoned(input logic [2:0] lead, input logic [11:0] data);
    frame_q.push_back({lead, data});
  endtask

  task automatic raise_enable();
    @(posedge clk);
    #1;
    enable       = 1'b1;
    en_cyc       = cyc;
    en_rise_pend = 1'b1;
  endtask

  task automatic wait_valids(input int n, input int budget);
    int target;
    target = valid_cnt + n;
    while (valid_cnt < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check_val("valid_count", valid_cnt, target);
  endtask

  task automatic wait_fall(input int budget);
    int target;
    target = fall_cnt + 1;
    while (fall_cnt < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check_val("cs_fall_seen", fall_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cs_n"}, adc_cs_n, 1);
    check_val({tag, "_sclk"}, adc_sclk, 0);
    check_val({tag, "_value"}, adc_value, 0);
    check_val({tag, "_valid"}, sample_valid, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int falls_snap;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic read, extremes with lead bits opposite to data, and back-to-back period.
    queue_frame(3'b111, 12'hA5C);
    queue_frame(3'b111, 12'h000);
    queue_frame(3'b000, 12'hFFF);
    queue_frame(3'b101, 12'h5A3);
    raise_enable();
    wait_valids(4, 4 * SAMPLE_PERIOD + 50);

    // Drop enable 60 cycles into a frame: it still completes, then nothing starts.
    queue_frame(3'b010, 12'h3C7);
    wait_fall(SAMPLE_PERIOD + 10);
    repeat (60) @(posedge clk);
    #1 enable = 1'b0;
    wait_valids(1, FRAME_CYCLES);
    falls_snap = fall_cnt;
    repeat (300) @(posedge clk);
    check_val("no_start_disabled", fall_cnt - falls_snap, 0);

    // Re-enable: cs_n falls on the next cycle.
    queue_frame(3'b111, 12'h123);
    raise_enable();
    wait_valids(1, FRAME_CYCLES + 10);

    // Reset 70 cycles into the following frame: no update, no pulse.
    queue_abandoned(3'b000, 12'hFFF);
    wait_fall(SAMPLE_PERIOD + 10);
    repeat (70) @(posedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    @(posedge clk);
    #1;
    reset     = 1'b0;
    have_fall = 1'b0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    check_val("exp_q_empty_at_reset", exp_q.size(), 0);
    falls_snap = fall_cnt;
    repeat (250) @(posedge clk);
    check_val("no_start_after_reset", fall_cnt - falls_snap, 0);

    // Ramp of samples; with ADC_AVG_EN the model yields 0x040,0x0C0,0x180,0x280,0x340.
    queue_frame(3'b111, 12'h100);
    queue_frame(3'b111, 12'h200);
    queue_frame(3'b111, 12'h300);
    queue_frame(3'b111, 12'h400);
    queue_frame(3'b111, 12'h400);
    raise_enable();
    wait_valids(5, 5 * SAMPLE_PERIOD + 50);
    #1 enable = 1'b0;
    repeat (SAMPLE_PERIOD) @(posedge clk);
    check_val("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Periodic SPI master for an external 12-bit serial ADC (MCP3201-class: mode 0, read-only, leading null/dummy bits, then MSB-first data).
- Upstream stage of the data memory's ADC register at 0xC000_000C; its adc_value output drives that register's adc_value input directly.
- Converts on a fixed sample period and holds the last complete result stable between updates, so the processor never reads a half-shifted word.

Parameters:
- CLK_DIV, 25: clk cycles per sclk half-period. Must be >= 4. 50 MHz clk gives 1 MHz sclk.
- LEAD_BITS, 3: sclk cycles per frame before data MSB. Their miso bits are ignored.
- SAMPLE_PERIOD, 50000: clk cycles between conversion starts. Must be >= FRAME_CYCLES + CLK_DIV.
- Derived constant FRAME_CYCLES = CLK_DIV + 2*CLK_DIV*(LEAD_BITS+12) + 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = periodic conversions run
- adc_miso  in  1  ADC serial data, asynchronous to clk
- adc_sclk  out  1  SPI clock, idles low
- adc_cs_n  out  1  ADC chip select, active low
- adc_value  out  12  last completed conversion, held stable between updates
- sample_valid  out  1  one-cycle pulse when adc_value updates
- busy  out  1  high while a frame is in progress (adc_cs_n low or DONE)

Behaviour:
- Clock and reset: single clock. Reset is synchronous, active-high, sampled on posedge clk.
- Reset values: adc_cs_n=1, adc_sclk=0, adc_value=0, sample_valid=0, busy=0, state=IDLE, all counters=0.
- Reset mid-frame: frame is abandoned. Outputs take reset values on the next edge, with no partial update of adc_value.
- miso input: passes through a 2-FF synchronizer before use (2 clk latency, covered by CLK_DIV >= 4).
- Period counter:
  - Held at 0 while enable=0.
  - Otherwise counts 0..SAMPLE_PERIOD-1 and wraps.
  - A start is issued when enable=1, counter==0 and state==IDLE.
  - First start therefore occurs the cycle after enable rises; later starts are exactly SAMPLE_PERIOD cycles apart.
- State IDLE: adc_cs_n=1, adc_sclk=0. On start, go to SETUP and drive adc_cs_n=0 on the same edge.
- State SETUP: hold for CLK_DIV cycles with adc_sclk=0, then go to SHIFT.
- State SHIFT: runs LEAD_BITS+12 sclk periods, each a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
  - The edge ending each high phase captures synchronized miso into a 12-bit shift register (shift left, LSB in).
  - Lead bits are shifted through and lost.
  - After the last low phase, go to DONE.
- State DONE (1 cycle):
  - adc_cs_n=1.
  - adc_value <= shift register.
  - sample_valid=1 for this cycle only.
  - Next state IDLE.
- Timing totals: start edge to sample_valid = FRAME_CYCLES. Exactly LEAD_BITS+12 sclk rising edges occur per frame.
- enable deasserted mid-frame: the frame completes normally and updates adc_value. No new start occurs until enable returns to 1.
- Start while not IDLE: impossible under the SAMPLE_PERIOD constraint. If the parameter is violated, the start is dropped, never queued.
- adc_value changes only in DONE. It is not affected by miso activity outside a frame.

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined:
  - Keep the last 4 raw results in a sample history, cleared to 0 on reset.
  - In DONE, adc_value <= (sum of the 4 newest raw samples including the current one) >> 2.
  - Sum is 14 bits wide; the shift truncates.
  - Zeros from reset count as samples until the history fills.
  - Latency and sample_valid timing are unchanged.
- Undefined: adc_value is the raw result.

Test Plan:
- Bench parameters for all scenarios: CLK_DIV=4, LEAD_BITS=3, SAMPLE_PERIOD=200, so FRAME_CYCLES=125.
- Basic read: ADC model shifts 1,1,1 then 0xA5C MSB-first, changing on sclk falling edges → adc_value=0xA5C, one sample_valid pulse 125 cycles after adc_cs_n falls, exactly 15 sclk rising edges.
- Timing: cs_n-fall to first sclk-rise = 4 cycles. sclk high/low = 4/4 cycles. Consecutive adc_cs_n falls are 200 cycles apart. adc_value is unchanged between pulses.
- Extremes: data 0x000 then 0xFFF → adc_value 0x000 then 0xFFF. Lead bits driven opposite to the data do not leak into the result.
- enable: drop enable at cycle 60 of a frame → frame completes and adc_value updates; no further adc_cs_n falls. Raise enable → adc_cs_n falls on the next cycle.
- Reset at cycle 70 of a frame with prior adc_value=0x123 → next edge gives adc_cs_n=1, adc_sclk=0, adc_value=0, busy=0, and no sample_valid pulse.
- ADC_AVG_EN: raw samples 0x100, 0x200, 0x300, 0x400, 0x400 → adc_value 0x040, 0x0C0, 0x180, 0x280, 0x340.
